mult_hilo_unit: RTL
===================

// Module: mult_hilo_unit
// PURPOSE
//  Multi-cycle shift-add multiplier for MULT/MULTU; sits directly upstream of the HI/LO read path.
//  Latches two operands on a start pulse, iterates WIDTH add/shift steps, optionally negates for
//  signed ops, then writes the 2*WIDTH-bit product atomically into its hi/lo output registers.
//  The mfhi/mflo path consumes hi/lo; busy lets control stall dependent instructions.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH bits, split hi (upper) / lo (lower)
// PORTS
//  clk        in   1      clock, all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  start      in   1      request a multiply; sampled only in IDLE
//  is_signed  in   1      1 = MULT (two's complement), 0 = MULTU; sampled with start
//  a          in   WIDTH  multiplicand (rs); sampled with start
//  b          in   WIDTH  multiplier (rt); sampled with start
//  busy       out  1      1 while in CALC or FIX
//  done       out  1      one-cycle pulse: hi/lo just updated
//  hi         out  WIDTH  product[2*WIDTH-1:WIDTH], registered
//  lo         out  WIDTH  product[WIDTH-1:0], registered
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, busy=0, done=0, hi=0, lo=0, internal regs 0.
//  States: IDLE -> CALC -> FIX -> IDLE.
//  IDLE: busy=0. If start=1 at edge E0:
//   - mcand = is_signed & a[MSB] ? -a : a; mplier = same for b (magnitudes, WIDTH-bit unsigned;
//     -0x80000000 = 0x80000000 is correct as unsigned magnitude).
//   - neg = is_signed & (a[MSB] ^ b[MSB]); acc (WIDTH+1 bits) = 0; count = 0; -> CALC.
//  CALC (edges E1..E_WIDTH, exactly WIDTH edges): per edge
//   - sum = acc + (mplier[0] ? mcand : 0) (WIDTH+1 bits, carry kept);
//   - {acc, mplier} <= {sum, mplier} >> 1; count++; after WIDTH steps -> FIX.
//   - Final product P = {acc[WIDTH-1:0], mplier}.
//  FIX (edge E_WIDTH+1): R = neg ? -P : P (2*WIDTH-bit two's complement);
//   hi <= R[2W-1:W], lo <= R[W-1:0], done <= 1, -> IDLE.
//  done high exactly the cycle after E_WIDTH+1; cleared at the next edge.
//  busy: 1 from after E0 through E_WIDTH+1 (WIDTH+1 cycles); 0 in the cycle done=1.
//  Latency: start edge to done-visible = WIDTH+1 edges (33 for WIDTH=32).
//  hi/lo hold their previous values for the whole operation; never show partial products.
//  start while busy: ignored, no queuing; operands not re-sampled.
//  start in the same cycle done=1 (state IDLE): accepted normally; back-to-back ops allowed.
//  Zero operand: still runs full WIDTH steps (fixed latency), result 0 (neg gives -0 = 0).
//  Reset mid-CALC/FIX: operation aborted, no done pulse, hi=lo=0.
//  a/b/is_signed may change freely after the start edge.
// TESTING
//  1 MULTU a=3 b=5 -> done exactly 33 edges after start edge, hi=0x00000000 lo=0x0000000F.
//  2 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
//  3 MULT a=0xFFFFFFFE(-2) b=3 -> hi=0xFFFFFFFF lo=0xFFFFFFFA; MULTU same -> hi=0x2 lo=0xFFFFFFFA.
//  4 MULT a=b=0x80000000 -> hi=0x40000000 lo=0; MULT a=0x80000000 b=1 -> hi=0xFFFFFFFF lo=0x80000000.
//  5 load hi/lo=(0,15) via test 1, start 7*9, pulse start again at cycle 5 with a=b=0xFFFFFFFF
//    -> second start ignored; hi/lo stay (0,15) until done, then (0,63); busy never glitches.
//  6 start 0x12345678*0x9ABCDEF0, assert rst at cycle 10 of CALC -> busy=0 hi=lo=0 immediately,
//    no done; release rst, restart same op -> hi=0x0B00EA4E lo=0x242D2080.

Source files
------------

// File: rtl/mult_hilo_unit.sv
// Purpose: multi-cycle shift-add multiplier (MULT/MULTU) feeding the HI/LO read path.
// Latency: start edge to done visible is WIDTH+1 edges; hi/lo update atomically with done.
// Backpressure: none; start is ignored while busy (no queuing), accepted again in the done cycle.
module mult_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Operand magnitudes and iteration state
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH:0]   acc;
    logic [CW-1:0]    count;
    logic             neg;

    // Combinational helpers
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] result;

    // Magnitudes of the incoming operands; the most negative value maps onto itself,
    // which is the correct unsigned magnitude.
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (is_signed && a[WIDTH-1]) a_mag = ~a + 1'b1;
        if (is_signed && b[WIDTH-1]) b_mag = ~b + 1'b1;
    end

    // One shift-add step: add the multiplicand when the current multiplier LSB is set,
    // keeping the carry in the extra accumulator bit.
    always_comb begin
        addend = mplier[0] ? mcand : '0;
        sum    = acc + {1'b0, addend};
    end

    // Final unsigned product and its sign-corrected form for signed operations.
    always_comb begin
        product = {acc[WIDTH-1:0], mplier};
        result  = neg ? (~product + 1'b1) : product;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: IDLE -> CALC (WIDTH steps) -> FIX (one write-back edge) -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = CALC;
            CALC: if (count == LAST_STEP) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // busy covers CALC and FIX only, so it is already low in the done cycle.
    assign busy = (state != IDLE);

    // Datapath: operand capture, iteration, and atomic hi/lo write-back with done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                CALC: begin
                    // {acc, mplier} <= {sum, mplier} >> 1
                    acc    <= sum >> 1;
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    count  <= count + 1'b1;
                end
                FIX: begin
                    hi   <= result[2*WIDTH-1:WIDTH];
                    lo   <= result[WIDTH-1:0];
                    done <= 1'b1;
                end
                default: begin
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule
